// File: rtl/dmem_dual_responder_if.sv
// Request/response channel between one pipeline MEM stage (master) and the data-memory responder (slave).
interface dmem_dual_responder_if #(
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_dual_responder.sv
// Two-port data-memory responder sharing one single-port word array, one access per cycle.
// Define DMEM_RR_ARB_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module dmem_dual_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dmem_dual_responder_if.slave  p1_if,
  dmem_dual_responder_if.slave  p2_if,
  output logic [15:0]           o_conflict_cnt
);

  logic              w_both;
  logic              w_grant1;
  logic              w_grant2;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused_addr_hi;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp1_valid;
  logic              r_rsp2_valid;
  logic [DATA_W-1:0] r_rsp1_rdata;
  logic [DATA_W-1:0] r_rsp2_rdata;
  logic [15:0]       r_conflict_cnt;
`ifdef DMEM_RR_ARB_EN
  logic              r_last_grant2;
`endif

  assign w_both = p1_if.req_valid & p2_if.req_valid;

  // Arbitration: at most one grant per cycle, none while reset is held
  always_comb begin
    w_grant1 = 1'b0;
    w_grant2 = 1'b0;
    if (i_rst) begin
      w_grant1 = 1'b0;
      w_grant2 = 1'b0;
    end else if (w_both) begin
`ifdef DMEM_RR_ARB_EN
      w_grant1 = r_last_grant2;
      w_grant2 = ~r_last_grant2;
`else
      w_grant1 = 1'b1;
      w_grant2 = 1'b0;
`endif
    end else begin
      w_grant1 = p1_if.req_valid;
      w_grant2 = p2_if.req_valid;
    end
  end

  assign p1_if.req_ready = w_grant1;
  assign p2_if.req_ready = w_grant2;

  // Upper address bits alias onto the array and are deliberately dropped
  assign w_unused_addr_hi = ^{p1_if.req_addr[31:ADDR_W], p2_if.req_addr[31:ADDR_W]};
  assign w_acc_addr = w_grant2 ? p2_if.req_addr[ADDR_W-1:0] : p1_if.req_addr[ADDR_W-1:0];
  assign w_wdata    = w_grant2 ? p2_if.req_wdata : p1_if.req_wdata;
  assign w_mem_we   = (w_grant1 & p1_if.req_we) | (w_grant2 & p2_if.req_we);
  assign w_rd_word  = r_mem[w_acc_addr];

  // Word array write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_acc_addr] <= w_wdata;
    end
  end

  // Response pulses, read data capture, contention counter and arbitration history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp1_valid   <= 1'b0;
      r_rsp2_valid   <= 1'b0;
      r_rsp1_rdata   <= {DATA_W{1'b0}};
      r_rsp2_rdata   <= {DATA_W{1'b0}};
      r_conflict_cnt <= 16'h0000;
`ifdef DMEM_RR_ARB_EN
      r_last_grant2  <= 1'b1;
`endif
    end else begin
      r_rsp1_valid <= w_grant1;
      r_rsp2_valid <= w_grant2;
      if (w_grant1) begin
        r_rsp1_rdata <= p1_if.req_we ? {DATA_W{1'b0}} : w_rd_word;
      end
      if (w_grant2) begin
        r_rsp2_rdata <= p2_if.req_we ? {DATA_W{1'b0}} : w_rd_word;
      end
      if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
`ifdef DMEM_RR_ARB_EN
      if (w_grant1 | w_grant2) begin
        r_last_grant2 <= w_grant2;
      end
`endif
    end
  end

  // A response falling due while reset is held is suppressed in that same cycle
  assign p1_if.rsp_valid = r_rsp1_valid & ~i_rst;
  assign p2_if.rsp_valid = r_rsp2_valid & ~i_rst;
  assign p1_if.rsp_rdata = i_rst ? {DATA_W{1'b0}} : r_rsp1_rdata;
  assign p2_if.rsp_rdata = i_rst ? {DATA_W{1'b0}} : r_rsp2_rdata;
  assign o_conflict_cnt  = i_rst ? 16'h0000 : r_conflict_cnt;

endmodule

// File: tb/tb_dmem_dual_responder.sv
// Self-checking bench for dmem_dual_responder: directed table, arbitration sequence,
// randomized traffic against a behavioural model, and counter saturation.
module tb_dmem_dual_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  dmem_dual_responder_if #(.DATA_W(32)) p1 ();
  dmem_dual_responder_if #(.DATA_W(32)) p2 ();

  dmem_dual_responder #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .p1_if          (p1),
    .p2_if          (p2),
    .o_conflict_cnt (conflict_cnt)
  );

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    bit          rst;
    req_t        q1;
    req_t        q2;
    bit          e_rdy1;
    bit          e_rdy2;
    bit          e_rv1;
    logic [31:0] e_rd1;
    bit          e_rv2;
    logic [31:0] e_rd2;
    logic [15:0] e_cnt;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_mem   [4096];
  bit          m_known [4096];
  bit          m_rv1, m_rv2;
  logic [31:0] m_rd1, m_rd2;
  bit          m_rdk1, m_rdk2;
  int          m_cnt;
`ifdef DMEM_RR_ARB_EN
  int          m_last;
`endif

  bit   cur_rst;
  req_t cur1, cur2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input req_t q1, input req_t q2);
    @(negedge clk);
    cur_rst = r;
    cur1 = q1;
    cur2 = q2;
    rst = r;
    p1.req_valid = q1.v; p1.req_we = q1.we; p1.req_addr = q1.a; p1.req_wdata = q1.d;
    p2.req_valid = q2.v; p2.req_we = q2.we; p2.req_addr = q2.a; p2.req_wdata = q2.d;
    #1;
  endtask

  function automatic int model_grant();
    if (cur_rst) return 0;
    if (cur1.v && cur2.v) begin
`ifdef DMEM_RR_ARB_EN
      return (m_last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (cur1.v) return 1;
    if (cur2.v) return 2;
    return 0;
  endfunction

  task automatic model_check();
    int g;
    g = model_grant();
    chk("ready1", {31'd0, p1.req_ready}, {31'd0, g == 1});
    chk("ready2", {31'd0, p2.req_ready}, {31'd0, g == 2});
    chk("rsp1_valid", {31'd0, p1.rsp_valid}, {31'd0, m_rv1 && !cur_rst});
    chk("rsp2_valid", {31'd0, p2.rsp_valid}, {31'd0, m_rv2 && !cur_rst});
    if (cur_rst || m_rdk1) chk("rsp1_rdata", p1.rsp_rdata, cur_rst ? 32'd0 : m_rd1);
    if (cur_rst || m_rdk2) chk("rsp2_rdata", p2.rsp_rdata, cur_rst ? 32'd0 : m_rd2);
    chk("conflict_cnt", {16'd0, conflict_cnt}, cur_rst ? 32'd0 : m_cnt);
  endtask

  // Advance the model across one rising edge using the currently applied inputs
  task automatic model_advance();
    int g;
    int ai;
    g = model_grant();
    if (cur_rst) begin
      m_rv1 = 0; m_rv2 = 0; m_rd1 = 0; m_rd2 = 0; m_rdk1 = 1; m_rdk2 = 1; m_cnt = 0;
`ifdef DMEM_RR_ARB_EN
      m_last = 2;
`endif
    end else begin
      m_rv1 = (g == 1);
      m_rv2 = (g == 2);
      if (g == 1) begin
        ai = int'(cur1.a % 32'd4096);
        if (cur1.we) begin m_rd1 = 0; m_rdk1 = 1; m_mem[ai] = cur1.d; m_known[ai] = 1; end
        else begin m_rd1 = m_mem[ai]; m_rdk1 = m_known[ai]; end
      end
      if (g == 2) begin
        ai = int'(cur2.a % 32'd4096);
        if (cur2.we) begin m_rd2 = 0; m_rdk2 = 1; m_mem[ai] = cur2.d; m_known[ai] = 1; end
        else begin m_rd2 = m_mem[ai]; m_rdk2 = m_known[ai]; end
      end
      if (cur1.v && cur2.v && m_cnt < 65535) m_cnt++;
`ifdef DMEM_RR_ARB_EN
      if (g != 0) m_last = g;
`endif
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.v  = ($urandom_range(0, 3) != 0);
    r.we = ($urandom_range(0, 2) == 0);
    r.a  = ($urandom & 32'hFFFF_F000) | 32'h0000_0100 | 32'($urandom_range(0, 15));
    r.d  = $urandom;
    return r;
  endfunction

  localparam req_t IDLE = '{1'b0, 1'b0, 32'h0, 32'h0};

  vec_t tbl [22];

  initial begin
    req_t n1, n2;
    int   g;
    bit   r;
    for (int i = 0; i < 4096; i++) m_known[i] = 0;
    m_rv1 = 0; m_rv2 = 0; m_rd1 = 0; m_rd2 = 0; m_rdk1 = 1; m_rdk2 = 1; m_cnt = 0;
`ifdef DMEM_RR_ARB_EN
    m_last = 2;
`endif
    rst = 1'b1;

    // {rst, q1, q2, rdy1, rdy2, rv1, rd1, rv2, rd2, cnt} observed in the same cycle
    tbl[0]  = '{1, '{1, 1, 32'h005, 32'h99}, IDLE,                 0, 0, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[1]  = '{1, IDLE, IDLE,                                     0, 0, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[2]  = '{0, '{1, 1, 32'h0A5, 32'hDEADBEEF}, IDLE,           1, 0, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[3]  = '{0, '{1, 0, 32'h0A5, 32'h0}, IDLE,                  1, 0, 1, 32'h0, 0, 32'h0, 16'd0};
    tbl[4]  = '{0, IDLE, IDLE,                                     0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 16'd0};
    tbl[5]  = '{0, IDLE, IDLE,                                     0, 0, 0, 32'hDEADBEEF, 0, 32'h0, 16'd0};
    tbl[6]  = '{0, '{1, 1, 32'h010, 32'h11}, IDLE,                 1, 0, 0, 32'hDEADBEEF, 0, 32'h0, 16'd0};
    tbl[7]  = '{0, IDLE, '{1, 1, 32'h020, 32'h22},                 0, 1, 1, 32'h0, 0, 32'h0, 16'd0};
    tbl[8]  = '{0, '{1, 0, 32'h010, 32'h0}, '{1, 0, 32'h020, 32'h0}, 1, 0, 0, 32'h0, 1, 32'h0, 16'd0};
    tbl[9]  = '{0, IDLE, '{1, 0, 32'h020, 32'h0},                  0, 1, 1, 32'h11, 0, 32'h0, 16'd1};
    tbl[10] = '{0, IDLE, IDLE,                                     0, 0, 0, 32'h11, 1, 32'h22, 16'd1};
    tbl[11] = '{0, IDLE, '{1, 1, 32'h1003, 32'h55},                0, 1, 0, 32'h11, 0, 32'h22, 16'd1};
    tbl[12] = '{0, '{1, 0, 32'h003, 32'h0}, IDLE,                  1, 0, 0, 32'h11, 1, 32'h0, 16'd1};
    tbl[13] = '{0, IDLE, IDLE,                                     0, 0, 1, 32'h55, 0, 32'h0, 16'd1};
    tbl[14] = '{0, '{1, 0, 32'h0A5, 32'h0}, IDLE,                  1, 0, 0, 32'h55, 0, 32'h0, 16'd1};
    tbl[15] = '{1, '{1, 1, 32'h0A5, 32'h12345678}, '{1, 0, 32'h0A5, 32'h0}, 0, 0, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[16] = '{0, '{1, 0, 32'h0A5, 32'h0}, IDLE,                  1, 0, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[17] = '{0, IDLE, IDLE,                                     0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 16'd0};
    tbl[18] = '{0, IDLE, '{1, 1, 32'h0B0, 32'hCAFEF00D},           0, 1, 0, 32'hDEADBEEF, 0, 32'h0, 16'd0};
    tbl[19] = '{1, IDLE, IDLE,                                     0, 0, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[20] = '{0, IDLE, '{1, 0, 32'h0B0, 32'h0},                  0, 1, 0, 32'h0, 0, 32'h0, 16'd0};
    tbl[21] = '{0, IDLE, IDLE,                                     0, 0, 0, 32'h0, 1, 32'hCAFEF00D, 16'd0};

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].q1, tbl[i].q2);
      chk($sformatf("t%0d ready1", i), {31'd0, p1.req_ready}, {31'd0, tbl[i].e_rdy1});
      chk($sformatf("t%0d ready2", i), {31'd0, p2.req_ready}, {31'd0, tbl[i].e_rdy2});
      chk($sformatf("t%0d rsp1_valid", i), {31'd0, p1.rsp_valid}, {31'd0, tbl[i].e_rv1});
      chk($sformatf("t%0d rsp1_rdata", i), p1.rsp_rdata, tbl[i].e_rd1);
      chk($sformatf("t%0d rsp2_valid", i), {31'd0, p2.rsp_valid}, {31'd0, tbl[i].e_rv2});
      chk($sformatf("t%0d rsp2_rdata", i), p2.rsp_rdata, tbl[i].e_rd2);
      chk($sformatf("t%0d conflict_cnt", i), {16'd0, conflict_cnt}, {16'd0, tbl[i].e_cnt});
      model_advance();
    end

    // Sustained contention: last grant before this went to port 2
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, '{1, 0, 32'h010, 32'h0}, '{1, 0, 32'h020, 32'h0});
`ifdef DMEM_RR_ARB_EN
      chk($sformatf("contend%0d ready1", i), {31'd0, p1.req_ready}, {31'd0, (i % 2) == 0});
      chk($sformatf("contend%0d ready2", i), {31'd0, p2.req_ready}, {31'd0, (i % 2) == 1});
`else
      chk($sformatf("contend%0d ready1", i), {31'd0, p1.req_ready}, 32'd1);
      chk($sformatf("contend%0d ready2", i), {31'd0, p2.req_ready}, 32'd0);
`endif
      model_advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, IDLE, IDLE);
      model_check();
      model_advance();
    end

    // Preload the random-traffic window
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, '{1, 1, 32'h100 + 32'(k), $urandom}, IDLE);
      model_check();
      model_advance();
    end

    // Randomized traffic; a stalled request is held unchanged until accepted
    n1 = rand_req();
    n2 = rand_req();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      apply(r, n1, n2);
      model_check();
      g = model_grant();
      model_advance();
      if (!cur1.v || g == 1) n1 = rand_req();
      if (!cur2.v || g == 2) n2 = rand_req();
    end

    // Counter saturation
    apply(1'b0, '{1, 0, 32'h100, 32'h0}, '{1, 0, 32'h101, 32'h0});
    repeat (70000) @(posedge clk);
    @(negedge clk); #1;
    chk("conflict_cnt saturated", {16'd0, conflict_cnt}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("conflict_cnt holds", {16'd0, conflict_cnt}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
